// File: rtl/uart_tx_core.sv
// UART transmitter with integrated bit-period timer: one byte per tx_start, serialised LSB-first on txd (8N1, or 8E1 with UART_TX_PARITY_EN).
// Latency: txd/tx_busy change on the edge after tx_start is accepted; tx_done pulses 10*BAUD_DIV (11*BAUD_DIV with parity) cycles later.
// Backpressure: tx_start is sampled only while tx_busy=0; requests made while busy are dropped, not queued.
//
// Optional feature macro: UART_TX_PARITY_EN (adds the even-parity bit and the PARITY state).
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset (aborts any frame, txd returns high)
//   tx_start  - request strobe, honoured only when idle
//   tx_data   - byte to send, captured on acceptance
//   txd       - registered serial line, idle high
//   tx_busy   - registered, high from acceptance until the end of the stop bit
//   tx_done   - registered one-cycle pulse when the stop bit completes
module uart_tx_core #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int BAUD_DIV = CLK_HZ / BAUD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam logic [15:0] DIV_M1 = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bit_end;
`ifdef UART_TX_PARITY_EN
    // Parity is taken from the byte at acceptance, since the shift register
    // is consumed while the data bits go out.
    logic        par_q, par_d;
`endif

    assign bit_end = (cnt_q == DIV_M1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif

        // Free-running bit timer while a frame is in flight; the wrap is the
        // bit boundary, so every bit is exactly BAUD_DIV cycles with no drift.
        if (state_q != IDLE) begin
            cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shift_d = tx_data;
                    busy_d  = 1'b1;
                    txd_d   = 1'b0;
                    cnt_d   = 16'd0;
                    idx_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_data;
`endif
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    txd_d   = shift_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_d   = par_q;
                        state_d = PARITY;
`else
                        txd_d   = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        // Next bit is the one about to land in shift[0].
                        txd_d = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    txd_d   = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                txd_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core at CLK_HZ=1000, BAUD=100 (10 cycles per bit).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_uart_tx_core;

    localparam int D = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       rst_n;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    int nvec;
    int nfail;

    uart_tx_core #(
        .CLK_HZ (1000),
        .BAUD   (100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish before 300000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends byte b and samples txd at the middle of every bit. exp holds the
    // hand-computed frame, bit k of exp = k-th bit on the line (start first).
    // inject_at > 0 pulses tx_start with 0x3C at that cycle of the frame.
    // hold keeps tx_start high so the next call's request is already pending.
    task automatic frame(input logic [7:0] b, input logic [10:0] exp,
                         input int inject_at, input bit hold, input string tag);
        logic [10:0] got;
        int          done_at;
        got     = '0;
        done_at = -1;
        tx_data  = b;
        tx_start = 1'b1;
        tick();
        if (!hold) tx_start = 1'b0;
        check({tag, "_acc_txd"}, txd, 1'b0);
        check({tag, "_acc_busy"}, tx_busy, 1'b1);
        tx_data = ~b;
        for (int c = 1; c <= NB * D; c++) begin
            if (c == inject_at) begin
                tx_data  = 8'h3C;
                tx_start = 1'b1;
            end
            tick();
            if (c == inject_at && !hold) tx_start = 1'b0;
            if (c % D == D / 2) got[c / D] = txd;
            if (tx_done && done_at < 0) done_at = c;
        end
        check({tag, "_bits"}, got, exp);
        check({tag, "_done_at"}, done_at, NB * D);
        check({tag, "_busy_end"}, tx_busy, 1'b0);
        check({tag, "_txd_end"}, txd, 1'b1);
    endtask

    initial begin
        logic bad;
        nvec     = 0;
        nfail    = 0;
        rst_n    = 1'b0;
        tx_start = 1'b0;
        tx_data  = 8'h00;

        // Reset held for 5 cycles, then 100 quiet cycles.
        repeat (5) tick();
        check("rst_txd", txd, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (txd !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad = 1'b1;
        end
        check("idle_quiet", bad, 1'b0);

`ifdef UART_TX_PARITY_EN
        frame(8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, -1, 1'b0, "a5");
        frame(8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, -1, 1'b0, "x07");
`else
        frame(8'hA5, {1'b0, 1'b1, 8'hA5, 1'b0}, -1, 1'b0, "a5");
        frame(8'h07, {1'b0, 1'b1, 8'h07, 1'b0}, -1, 1'b0, "x07");
`endif
        // tx_done is a single-cycle pulse.
        tick();
        check("done_pulse_width", tx_done, 1'b0);

        // Request while busy is dropped; the frame in flight is untouched.
`ifdef UART_TX_PARITY_EN
        frame(8'h55, {1'b1, 1'b0, 8'h55, 1'b0}, 35, 1'b0, "busy_inj");
`else
        frame(8'h55, {1'b0, 1'b1, 8'h55, 1'b0}, 35, 1'b0, "busy_inj");
`endif
        bad = 1'b0;
        for (int i = 0; i < 2 * D; i++) begin
            tick();
            if (tx_busy !== 1'b0 || txd !== 1'b1) bad = 1'b1;
        end
        check("busy_inj_no_queue", bad, 1'b0);

        // Back-to-back: tx_start held high, one idle cycle (the tx_done
        // cycle, txd=1) separates the stop bit from the next start bit.
`ifdef UART_TX_PARITY_EN
        frame(8'h00, {1'b1, 1'b0, 8'h00, 1'b0}, -1, 1'b1, "b2b0");
        frame(8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}, -1, 1'b0, "b2b1");
`else
        frame(8'h00, {1'b0, 1'b1, 8'h00, 1'b0}, -1, 1'b1, "b2b0");
        frame(8'hFF, {1'b0, 1'b1, 8'hFF, 1'b0}, -1, 1'b0, "b2b1");
`endif
        tick();

        // Reset 45 cycles into a frame.
        tx_data  = 8'h5A;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        repeat (45) tick();
        rst_n = 1'b0;
        #1;
        check("abort_txd", txd, 1'b1);
        check("abort_busy", tx_busy, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < NB * D; i++) begin
            tick();
            if (tx_done !== 1'b0 || tx_busy !== 1'b0) bad = 1'b1;
        end
        check("abort_no_done", bad, 1'b0);
`ifdef UART_TX_PARITY_EN
        frame(8'h5A, {1'b1, 1'b0, 8'h5A, 1'b0}, -1, 1'b0, "after_abort");
`else
        frame(8'h5A, {1'b0, 1'b1, 8'h5A, 1'b0}, -1, 1'b0, "after_abort");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/uart_tx_core.md
# uart_tx_core

UART transmitter with an integrated bit-period timer: accepts one byte per handshake and serialises it LSB-first on `txd` as a start bit, 8 data bits, an optional even-parity bit, and one stop bit. It is the transmit-side counterpart of the receive path and its baud generator in the serial peripheral. It drives the board's RS-232 transceiver input directly.

## Interface
- `CLK_HZ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `BAUD_DIV`, default CLK_HZ/BAUD (5208): clock cycles per bit, integer division. Legal range 2..65535; the counter is 16 bits.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `tx_start`, input, 1: request strobe. Sampled only while `tx_busy`=0.
- `tx_data`, input, 8: byte to send. Captured in the cycle `tx_start` is accepted.
- `txd`, output, 1: serial line, idle high. Registered.
- `tx_busy`, output, 1: high from acceptance until the end of the stop bit. Registered.
- `tx_done`, output, 1: one-cycle pulse when the stop bit completes. Registered.

## Operation
- Reset values: `txd`=1, `tx_busy`=0, `tx_done`=0. The FSM is in IDLE, the bit counter is 0 and the shift register is 0.
- FSM states are IDLE, START, DATA, PARITY (present only with the macro), and STOP.
- IDLE: on `tx_start`=1, latch `tx_data` into the shift register, set `tx_busy`=1 and `txd`=0, clear the bit-period counter and the bit index, then go to START.
- Bit-period counter: counts 0..BAUD_DIV-1, then wraps. The wrap marks the end of the current bit. Every bit, including stop, lasts exactly BAUD_DIV cycles.
- START: at the end of the bit, drive bit 0 of the shift register and go to DATA.
- DATA: at the end of each bit, shift right and increment the bit index (3 bits).
  - After the 8th data bit, go to PARITY if `UART_TX_PARITY_EN` is defined, otherwise go to STOP with `txd`=1.
- PARITY: drive the XOR of the latched byte (even parity). At the end of the bit, go to STOP with `txd`=1.
- STOP: at the end of the bit, go to IDLE. On that same edge, `tx_busy` goes to 0 and `tx_done` goes to 1 for one cycle.
- `tx_start` while `tx_busy`=1 is ignored: no queuing, and the frame in flight is not corrupted.
- `tx_data` changes after acceptance have no effect.
- Asserting `rst_n` mid-frame aborts the frame immediately. `txd` returns to 1 asynchronously and no `tx_done` is produced.

## Timing
- Acceptance latency: `tx_start` sampled high at edge N, with `tx_busy` low, causes `txd`=0 and `tx_busy`=1 to be visible after edge N.
- Frame length from edge N to the `tx_done` edge is 10×BAUD_DIV cycles without parity and 11×BAUD_DIV cycles with parity.
- `tx_done` and `tx_busy` falling occur on the same edge. `txd` is already 1, since the stop bit is still high.
- Back-to-back frames: a `tx_start` held high through the `tx_done` cycle is accepted on the next edge. The minimum idle gap between frames is therefore 1 clock cycle at 1 level.
- Bit edges fall at exact multiples of BAUD_DIV from edge N. There is no cumulative drift within a frame.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and the parity bit are compiled in, giving frames of 11 bits (8E1).
- `UART_TX_PARITY_EN` undefined: there is no PARITY state and no parity logic, giving frames of 10 bits (8N1).

## Test plan
- Reset: hold `rst_n`=0 for 5 cycles, then release. Required: `txd`=1, `tx_busy`=0, `tx_done`=0, and no activity for 100 cycles.
- Byte 0xA5 with CLK_HZ=1000 and BAUD=100 (BAUD_DIV=10), no macro. Required:
  - `txd` samples taken at the mid-point of each bit read 0,1,0,1,0,0,1,0,1,1.
  - `tx_done` pulses exactly 100 cycles after acceptance.
- Byte 0x07 with `UART_TX_PARITY_EN` defined, BAUD_DIV=10. Required:
  - Data bits read 1,1,1,0,0,0,0,0.
  - The parity bit is 1.
  - The stop bit is 1.
  - `tx_done` pulses at 110 cycles.
- Pulse `tx_start` with 0x3C while busy, 35 cycles into a frame carrying 0x55. Required: the 0x55 frame is unchanged and 0x3C is never transmitted.
- Hold `tx_start`=1 continuously with data 0x00, then 0xFF. Required: two frames, with exactly one cycle of `txd`=1 between the stop bit and the next start bit.
- Drive `rst_n` low 45 cycles into a frame. Required: `txd`=1 immediately, `tx_busy`=0, no `tx_done` pulse, and the next request transmits a full, correct frame.
